// File: rtl/wash_controller.sv
// Washing-machine sequencer: fill/wash/drain/rinse/spin phases driven by external phase-timer pulses, with a watchdog.
// Optional build macro PAUSE_EN: door opening in an active phase pauses and restarts the phase instead of faulting.
module wash_controller #(
  parameter int WDOG_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       door_closed,
  input  logic [1:0] load,
  input  logic       td,
  input  logic       tf,
  input  logic       tr,
  input  logic       ts,
  input  logic       tw,
  output logic       timer_clr,
  output logic [1:0] load_sel,
  output logic       water_valve,
  output logic       agitator,
  output logic       drain_pump,
  output logic       spin_motor,
  output logic       door_lock,
  output logic       done,
  output logic       fault,
  output logic [3:0] state
);

  // state | meaning
  // IDLE  | waiting for start with door closed
  // FILL  | filling for wash
  // WASH  | agitating
  // DRAIN | pumping out; next is RFILL or SPIN depending on rinse_done
  // RFILL | filling for rinse
  // RINSE | agitating rinse
  // SPIN  | final spin with pump on
  // DONE  | cycle complete, wait for start to drop
  // FAULT | watchdog or door fault, exits only on reset
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FILL  = 4'd1,
    S_WASH  = 4'd2,
    S_DRAIN = 4'd3,
    S_RFILL = 4'd4,
    S_RINSE = 4'd5,
    S_SPIN  = 4'd6,
    S_DONE  = 4'd7,
    S_FAULT = 4'd8
  } state_t;

  localparam logic [7:0] WDOG_MAX = 8'(WDOG_LIMIT);

  state_t     cur;
  state_t     nxt;
  logic       rinse_done;
  logic [7:0] wdog;
  logic       active;
  logic       nxt_active;
  logic       set_rinse;
  logic       clr_rinse;
  logic       latch_load;
  logic       hold_pause;
  logic       pulses_ok;
  logic       tf_unused;

  assign active     = (cur >= S_FILL) && (cur <= S_SPIN);
  assign nxt_active = (nxt >= S_FILL) && (nxt <= S_SPIN);
  assign pulses_ok  = !timer_clr;
  assign tf_unused  = tf;
  assign state      = cur;

  // Priority: door condition > abort > timer pulse > watchdog (watchdog only when nothing else moves).
  always_comb begin
    nxt        = cur;
    set_rinse  = 1'b0;
    clr_rinse  = 1'b0;
    latch_load = 1'b0;
    hold_pause = 1'b0;
    if (active && !door_closed) begin
`ifdef PAUSE_EN
      hold_pause = 1'b1;
`else
      nxt = S_FAULT;
`endif
    end else if (active && abort && (cur != S_DRAIN) && (cur != S_SPIN)) begin
      nxt       = S_DRAIN;
      set_rinse = 1'b1;
    end else begin
      case (cur)
        S_IDLE: begin
          if (start && door_closed) begin
            nxt        = S_FILL;
            latch_load = 1'b1;
          end
        end
        S_FILL:  if (tw && pulses_ok) nxt = S_WASH;
        S_WASH:  if (ts && pulses_ok) nxt = S_DRAIN;
        S_DRAIN: if (td && pulses_ok) nxt = rinse_done ? S_SPIN : S_RFILL;
        S_RFILL: if (tw && pulses_ok) nxt = S_RINSE;
        S_RINSE: begin
          if (tr && pulses_ok) begin
            nxt       = S_DRAIN;
            set_rinse = 1'b1;
          end
        end
        S_SPIN:  if (ts && pulses_ok) nxt = S_DONE;
        S_DONE: begin
          if (!start) begin
            nxt       = S_IDLE;
            clr_rinse = 1'b1;
          end
        end
        default: nxt = S_FAULT;
      endcase
      if (active && (nxt == cur) && (wdog >= WDOG_MAX)) nxt = S_FAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= S_IDLE;
      load_sel    <= 2'd0;
      rinse_done  <= 1'b0;
      wdog        <= 8'd0;
      timer_clr   <= 1'b0;
      water_valve <= 1'b0;
      agitator    <= 1'b0;
      drain_pump  <= 1'b0;
      spin_motor  <= 1'b0;
      door_lock   <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      cur <= nxt;
      if (latch_load) load_sel <= (load == 2'd3) ? 2'd2 : load;
      if (set_rinse)      rinse_done <= 1'b1;
      else if (clr_rinse) rinse_done <= 1'b0;
      timer_clr <= (nxt != cur) || hold_pause;
      if ((nxt != cur) || hold_pause || !nxt_active) wdog <= 8'd0;
      else                                           wdog <= wdog + 8'd1;
      // Outputs are registered from the next state so they track the state register exactly.
      water_valve <= !hold_pause && ((nxt == S_FILL) || (nxt == S_RFILL));
      agitator    <= !hold_pause && ((nxt == S_WASH) || (nxt == S_RINSE));
      drain_pump  <= !hold_pause && ((nxt == S_DRAIN) || (nxt == S_SPIN) || (nxt == S_FAULT));
      spin_motor  <= !hold_pause && (nxt == S_SPIN);
      door_lock   <= nxt_active;
      done        <= (nxt == S_DONE);
      fault       <= (nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_wash_controller.sv
// Self-checking bench for wash_controller: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a phase-level reference model.
module tb_wash_controller;
  localparam int LIMIT = 10;
  localparam int TD = 0, TF = 1, TR = 2, TS = 3, TW = 4;

  logic       clk = 1'b0;
  logic       reset, start, abort, door_closed;
  logic [1:0] load;
  logic [4:0] tp;
  logic       timer_clr, water_valve, agitator, drain_pump, spin_motor, door_lock, done, fault;
  logic [1:0] load_sel;
  logic [3:0] state;

  wash_controller #(.WDOG_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .door_closed(door_closed),
    .load(load), .td(tp[TD]), .tf(tp[TF]), .tr(tp[TR]), .ts(tp[TS]), .tw(tp[TW]),
    .timer_clr(timer_clr), .load_sel(load_sel), .water_valve(water_valve), .agitator(agitator),
    .drain_pump(drain_pump), .spin_motor(spin_motor), .door_lock(door_lock), .done(done),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase, cycles spent in phase, first-cycle flag, rinse flag, latched load.
  int m_st = 0, m_age = 0, m_ld = 0;
  bit m_clr = 0, m_rinse = 0, m_pause = 0;

  always @(posedge clk) begin
    int nst;
    bit act, pz;
    if (reset) begin
      m_st = 0; m_age = 0; m_ld = 0; m_clr = 0; m_rinse = 0; m_pause = 0;
    end else begin
      nst = m_st;
      act = (m_st >= 1) && (m_st <= 6);
      pz  = 0;
      if (act && !door_closed) begin
`ifdef PAUSE_EN
        pz = 1;
`else
        nst = 8;
`endif
      end else if (act && abort && (m_st == 1 || m_st == 2 || m_st == 4 || m_st == 5)) begin
        nst = 3; m_rinse = 1;
      end else begin
        if (m_st == 0 && start && door_closed) begin
          nst = 1; m_ld = (load == 2'd3) ? 2 : int'(load);
        end
        if (act && !m_clr) begin
          if (m_st == 1 && tp[TW]) nst = 2;
          if (m_st == 2 && tp[TS]) nst = 3;
          if (m_st == 3 && tp[TD]) nst = m_rinse ? 6 : 4;
          if (m_st == 4 && tp[TW]) nst = 5;
          if (m_st == 5 && tp[TR]) begin nst = 3; m_rinse = 1; end
          if (m_st == 6 && tp[TS]) nst = 7;
        end
        if (m_st == 7 && !start) begin nst = 0; m_rinse = 0; end
        if (act && nst == m_st && m_age >= LIMIT) nst = 8;
      end
      if (pz)               begin m_clr = 1; m_age = 0; m_pause = 1; end
      else if (nst != m_st) begin m_clr = 1; m_age = 0; m_pause = 0; end
      else begin
        m_clr = 0; m_pause = 0;
        m_age = act ? m_age + 1 : 0;
      end
      m_st = nst;
    end
  end

  function automatic logic [14:0] exp_vec();
    logic [8:0] wv_t, ag_t, dp_t, sm_t, dl_t, dn_t, ft_t;
    logic       p;
    wv_t = 9'b000010010; ag_t = 9'b000100100; dp_t = 9'b101001000; sm_t = 9'b001000000;
    dl_t = 9'b001111110; dn_t = 9'b010000000; ft_t = 9'b100000000;
    p = m_pause;
    return {4'(m_st), m_clr, 2'(m_ld), wv_t[m_st] & ~p, ag_t[m_st] & ~p, dp_t[m_st] & ~p,
            sm_t[m_st] & ~p, dl_t[m_st], dn_t[m_st], ft_t[m_st]};
  endfunction

  logic [14:0] act_vec;
  assign act_vec = {state, timer_clr, load_sel, water_valve, agitator, drain_pump, spin_motor,
                    door_lock, done, fault};

  always @(negedge clk) begin
    if (chk_en) chk("cycle_outputs", int'(act_vec), int'(exp_vec()));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Caller has just entered a phase; pulse is sampled in the fourth cycle of that phase.
  task automatic run_pulse(input int idx);
    step(); step(); step();
    tp[idx] = 1'b1;
    step();
    tp[idx] = 1'b0;
  endtask

  initial begin
    reset = 1; start = 0; abort = 0; door_closed = 1; load = 0; tp = '0;
    step(); step();
    reset = 0;
    chk_en = 1;
    chk("reset_state", int'(state), 0);
    chk("reset_outputs", int'({timer_clr, load_sel, water_valve, agitator, drain_pump,
                               spin_motor, door_lock, done, fault}), 0);

    // Oversized load request is clamped, full run through rinse and spin.
    load = 2'd3; start = 1;
    step();
    chk("start_state", int'(state), 1);
    chk("start_load_sel", int'(load_sel), 2);
    chk("start_timer_clr", int'(timer_clr), 1);
    chk("start_water_valve", int'(water_valve), 1);
    start = 0; load = 0;
    step();
    chk("fill_timer_clr_drop", int'(timer_clr), 0);
    chk("fill_hold_state", int'(state), 1);
    run_pulse(TW); chk("run_wash", int'(state), 2);
    run_pulse(TS); chk("run_drain1", int'(state), 3);
    run_pulse(TD); chk("run_rfill", int'(state), 4);
    run_pulse(TW); chk("run_rinse", int'(state), 5);
    run_pulse(TR); chk("run_drain2", int'(state), 3);
    run_pulse(TD); chk("run_spin", int'(state), 6);
    chk("run_spin_motor", int'(spin_motor), 1);
    run_pulse(TS); chk("run_done", int'(state), 7);
    chk("run_done_flag", int'(done), 1);
    step();
    chk("run_back_idle", int'(state), 0);

    // Pulse during the timer-clear cycle is ignored, one cycle later it counts.
    start = 1; load = 1;
    step();
    start = 0; tp[TW] = 1;
    step();
    chk("clr_cycle_ignored", int'(state), 1);
    step();
    tp[TW] = 0;
    chk("pulse_after_clr", int'(state), 2);
    chk("latched_medium", int'(load_sel), 1);

    // Abort in WASH skips the rinse.
    step();
    abort = 1;
    step();
    abort = 0;
    chk("abort_to_drain", int'(state), 3);
    run_pulse(TD); chk("abort_skip_rinse", int'(state), 6);
    run_pulse(TS); chk("abort_done", int'(state), 7);
    step();
    chk("abort_idle", int'(state), 0);

    // Watchdog: no pulses in FILL.
    start = 1;
    step();
    start = 0;
    repeat (LIMIT) step();
    chk("wdog_not_yet", int'(state), 1);
    step();
    chk("wdog_fault_state", int'(state), 8);
    chk("wdog_fault_flag", int'(fault), 1);
    chk("wdog_drain_pump", int'(drain_pump), 1);
    start = 1;
    repeat (3) step();
    chk("fault_sticky", int'(state), 8);
    start = 0; reset = 1;
    step();
    reset = 0;
    chk("fault_reset_idle", int'(state), 0);

    // Door opened in RINSE.
    start = 1;
    step();
    start = 0;
    run_pulse(TW); run_pulse(TS); run_pulse(TD); run_pulse(TW);
    chk("door_in_rinse", int'(state), 5);
    door_closed = 0;
    step();
`ifdef PAUSE_EN
    chk("pause_state", int'(state), 5);
    chk("pause_agitator", int'(agitator), 0);
    chk("pause_door_lock", int'(door_lock), 1);
    step();
    door_closed = 1;
    run_pulse(TR);
    chk("pause_resume", int'(state), 3);
`else
    chk("door_fault_state", int'(state), 8);
    chk("door_fault_flag", int'(fault), 1);
`endif
    door_closed = 1; reset = 1;
    step();
    reset = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 79) == 0);
      start       = ($urandom_range(0, 3) == 0);
      abort       = ($urandom_range(0, 39) == 0);
      door_closed = ($urandom_range(0, 119) != 0);
      load        = 2'($urandom_range(0, 3));
      for (int b = 0; b < 5; b++) tp[b] = ($urandom_range(0, 5) == 0);
      step();
    end

    reset = 1; tp = '0; start = 0; abort = 0;
    step();
    chk("final_reset", int'(state), 0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
